// File: rtl/dpd_fb_agc.sv
// Feedback-path AGC: scales PA feedback by a Q2.14 gain and, on start, steps the gain
// until windowed |fb_out| matches windowed |ref|. Datapath latency 2 cycles; no backpressure.
module dpd_fb_agc #(
    parameter int          WIN_LOG2  = 8,
    parameter logic [15:0] GAIN_INIT = 16'h4000,
    parameter logic [15:0] STEP      = 16'd16,
    parameter int          TOL_SHIFT = 6,
    parameter int          MAX_ITER  = 64
) (
    input  logic               clk,
    input  logic               reset_b,
    input  logic               start,
    input  logic signed [19:0] sig_ref_i,
    input  logic signed [19:0] sig_ref_q,
    input  logic signed [19:0] sig_fb_i,
    input  logic signed [19:0] sig_fb_q,
    output logic signed [19:0] sig_fb_out_i,
    output logic signed [19:0] sig_fb_out_q,
    output logic [15:0]        gain,
    output logic               busy,
    output logic               locked,
    output logic               fail
);
    localparam int AW = 21 + WIN_LOG2;
    localparam int CW = (WIN_LOG2 > 2) ? WIN_LOG2 : 2;
    localparam int IW = $clog2(MAX_ITER + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_ACCUM = 2'd2;
    localparam logic [1:0] ST_EVAL  = 2'd3;

    localparam logic [CW-1:0] FLUSH_LAST = CW'(3);
    localparam logic [CW-1:0] ACCUM_LAST = CW'((1 << WIN_LOG2) - 1);

    // Q2.14 scaling: drop 14 fraction bits (floor), then clip to s20.
    function automatic logic signed [19:0] sat_scale(input logic signed [36:0] p);
        logic signed [22:0] s;
        s = 23'(p >>> 14);
        if (s > 23'sd524287) begin
            return 20'sd524287;
        end else if (s < -23'sd524288) begin
            return -20'sd524288;
        end else begin
            return s[19:0];
        end
    endfunction

    // Alpha-max-plus-beta-min with alpha = 1, beta = 1/2; 21 bits keeps |-2^19| exact.
    function automatic logic [20:0] mag21(input logic signed [19:0] a, input logic signed [19:0] b);
        logic [20:0] ea, eb, aa, ab, mx, mn;
        ea = {a[19], a};
        eb = {b[19], b};
        aa = a[19] ? (~ea + 21'd1) : ea;
        ab = b[19] ? (~eb + 21'd1) : eb;
        mx = (aa > ab) ? aa : ab;
        mn = (aa > ab) ? ab : aa;
        return mx + (mn >> 1);
    endfunction

    logic signed [36:0] prod_i_q, prod_i_d, prod_q_q, prod_q_d;
    logic signed [19:0] out_i_q, out_i_d, out_q_q, out_q_d;
    logic [20:0]        mag_fb_q, mag_fb_d;
    logic [20:0]        mag_ref_q, mag_ref_d;
    logic [20:0]        ref_d1_q, ref_d1_d, ref_d2_q, ref_d2_d;
    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [IW-1:0]      iter_q, iter_d;
    logic [AW-1:0]      acc_ref_q, acc_ref_d, acc_fb_q, acc_fb_d;
    logic [15:0]        gain_q, gain_d;
    logic               locked_q, locked_d, fail_q, fail_d;

    logic signed [16:0] gain_s;
    logic [AW-1:0]      acc_diff, acc_tol;
    logic [16:0]        gain_up, gain_dn_lim;
    logic [IW-1:0]      iter_nxt;

    always_comb begin
        gain_s    = {1'b0, gain_q};
        prod_i_d  = 37'(sig_fb_i) * 37'(gain_s);
        prod_q_d  = 37'(sig_fb_q) * 37'(gain_s);
        out_i_d   = sat_scale(prod_i_q);
        out_q_d   = sat_scale(prod_q_q);
        mag_fb_d  = mag21(out_i_q, out_q_q);
        // Reference magnitude rides two extra stages to line up with the multiplier.
        mag_ref_d = mag21(sig_ref_i, sig_ref_q);
        ref_d1_d  = mag_ref_q;
        ref_d2_d  = ref_d1_q;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        iter_d      = iter_q;
        acc_ref_d   = acc_ref_q;
        acc_fb_d    = acc_fb_q;
        gain_d      = gain_q;
        locked_d    = locked_q;
        fail_d      = fail_q;
        acc_diff    = (acc_fb_q > acc_ref_q) ? (acc_fb_q - acc_ref_q) : (acc_ref_q - acc_fb_q);
        acc_tol     = acc_ref_q >> TOL_SHIFT;
        gain_up     = {1'b0, gain_q} + {1'b0, STEP};
        gain_dn_lim = {1'b0, STEP} + {1'b0, STEP};
        iter_nxt    = iter_q + IW'(1);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    locked_d = 1'b0;
                    fail_d   = 1'b0;
                    iter_d   = '0;
                    cnt_d    = '0;
                    state_d  = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                acc_ref_d = '0;
                acc_fb_d  = '0;
                if (cnt_q == FLUSH_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_ACCUM;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_ACCUM: begin
                acc_ref_d = acc_ref_q + AW'(ref_d2_q);
                acc_fb_d  = acc_fb_q + AW'(mag_fb_q);
                cnt_d     = cnt_q + CW'(1);
                if (cnt_q == ACCUM_LAST) begin
                    state_d = ST_EVAL;
                end
            end
            default: begin
                if (acc_diff <= acc_tol) begin
                    locked_d = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    if (acc_fb_q > acc_ref_q) begin
                        // Floor at STEP so the gain never reaches zero.
                        gain_d = ({1'b0, gain_q} < gain_dn_lim) ? STEP : (gain_q - STEP);
                    end else begin
                        gain_d = gain_up[16] ? 16'hFFFF : gain_up[15:0];
                    end
                    iter_d = iter_nxt;
                    cnt_d  = '0;
                    if (iter_nxt == IW'(MAX_ITER)) begin
                        fail_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_FLUSH;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            prod_i_q  <= '0;
            prod_q_q  <= '0;
            out_i_q   <= '0;
            out_q_q   <= '0;
            mag_fb_q  <= '0;
            mag_ref_q <= '0;
            ref_d1_q  <= '0;
            ref_d2_q  <= '0;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            iter_q    <= '0;
            acc_ref_q <= '0;
            acc_fb_q  <= '0;
            gain_q    <= GAIN_INIT;
            locked_q  <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            prod_i_q  <= prod_i_d;
            prod_q_q  <= prod_q_d;
            out_i_q   <= out_i_d;
            out_q_q   <= out_q_d;
            mag_fb_q  <= mag_fb_d;
            mag_ref_q <= mag_ref_d;
            ref_d1_q  <= ref_d1_d;
            ref_d2_q  <= ref_d2_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            iter_q    <= iter_d;
            acc_ref_q <= acc_ref_d;
            acc_fb_q  <= acc_fb_d;
            gain_q    <= gain_d;
            locked_q  <= locked_d;
            fail_q    <= fail_d;
        end
    end

    assign sig_fb_out_i = out_i_q;
    assign sig_fb_out_q = out_q_q;
    assign gain         = gain_q;
    assign busy         = (state_q != ST_IDLE);
    assign locked       = locked_q;
    assign fail         = fail_q;
endmodule

// File: tb/tb_dpd_fb_agc.sv
// Directed + randomized bench for dpd_fb_agc against an arithmetic reference model.
module tb_dpd_fb_agc;
    localparam int WIN      = 8;
    localparam int ITER_CYC = 4 + (1 << WIN) + 1;

    logic clk;
    logic reset_b;
    logic start_a [3];
    logic signed [19:0] ri [3], rq [3], fi [3], fq [3], oi [3], oq [3];
    logic [15:0] g [3];
    logic bsy [3], lck [3], fl [3];

    int total = 0;
    int bad   = 0;
    int steps [3] = '{16, 1024, 65535};
    int mg    [3];

    dpd_fb_agc u_dflt (
        .clk(clk), .reset_b(reset_b), .start(start_a[0]),
        .sig_ref_i(ri[0]), .sig_ref_q(rq[0]), .sig_fb_i(fi[0]), .sig_fb_q(fq[0]),
        .sig_fb_out_i(oi[0]), .sig_fb_out_q(oq[0]), .gain(g[0]),
        .busy(bsy[0]), .locked(lck[0]), .fail(fl[0])
    );
    dpd_fb_agc #(.STEP(16'd1024)) u_up (
        .clk(clk), .reset_b(reset_b), .start(start_a[1]),
        .sig_ref_i(ri[1]), .sig_ref_q(rq[1]), .sig_fb_i(fi[1]), .sig_fb_q(fq[1]),
        .sig_fb_out_i(oi[1]), .sig_fb_out_q(oq[1]), .gain(g[1]),
        .busy(bsy[1]), .locked(lck[1]), .fail(fl[1])
    );
    dpd_fb_agc #(.STEP(16'hFFFF)) u_sat (
        .clk(clk), .reset_b(reset_b), .start(start_a[2]),
        .sig_ref_i(ri[2]), .sig_ref_q(rq[2]), .sig_fb_i(fi[2]), .sig_fb_q(fq[2]),
        .sig_fb_out_i(oi[2]), .sig_fb_out_q(oq[2]), .gain(g[2]),
        .busy(bsy[2]), .locked(lck[2]), .fail(fl[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: gain applied as exact real-valued Q2.14 multiply, floored, clipped to s20.
    function automatic int m_scale(input int f, input int gv);
        longint p;
        p = longint'(f) * longint'(gv);
        p = p >>> 14;
        if (p > 524287) p = 524287;
        if (p < -524288) p = -524288;
        return int'(p);
    endfunction

    function automatic int m_mag(input int a, input int b);
        int aa, ab;
        aa = (a < 0) ? -a : a;
        ab = (b < 0) ? -b : b;
        return (aa > ab) ? (aa + ab / 2) : (ab + aa / 2);
    endfunction

    // With constant inputs each window sum is simply 2^WIN times one sample magnitude.
    task automatic m_cal(input int step, input int g0, input int r_i, input int r_q,
                         input int f_i, input int f_q,
                         output int g_o, output int lk, output int fa, output int it);
        longint ar, af, d;
        int gv;
        gv = g0; lk = 0; fa = 0; it = 0;
        forever begin
            ar = longint'(m_mag(r_i, r_q)) * (1 << WIN);
            af = longint'(m_mag(m_scale(f_i, gv), m_scale(f_q, gv))) * (1 << WIN);
            d  = (af > ar) ? af - ar : ar - af;
            it++;
            if (d <= ar / 64) begin
                lk = 1;
                break;
            end
            if (af > ar) gv = (gv - step < step) ? step : gv - step;
            else         gv = (gv + step > 65535) ? 65535 : gv + step;
            if (it == 64) begin
                fa = 1;
                break;
            end
        end
        g_o = gv;
    endtask

    task automatic run_cal(input int k, input string tag, input bit poke);
        int eg, el, ef, ei, cyc;
        m_cal(steps[k], mg[k], int'(ri[k]), int'(rq[k]), int'(fi[k]), int'(fq[k]), eg, el, ef, ei);
        repeat (4) @(negedge clk);
        start_a[k] = 1'b1;
        @(negedge clk);
        start_a[k] = 1'b0;
        chk({tag, "_busy_rise"}, bsy[k], 1);
        chk({tag, "_flags_clr"}, {lck[k], fl[k]}, 0);
        cyc = 0;
        while (bsy[k] === 1'b1 && cyc < 70 * ITER_CYC) begin
            if (poke) start_a[k] = (cyc == 100);
            @(negedge clk);
            cyc++;
        end
        start_a[k] = 1'b0;
        chk({tag, "_busy_cycles"}, cyc, ei * ITER_CYC);
        chk({tag, "_gain"}, g[k], eg);
        chk({tag, "_locked"}, lck[k], el);
        chk({tag, "_fail"}, fl[k], ef);
        mg[k] = eg;
    endtask

    task automatic dp_rand(input int k, input int n, input string tag);
        int hi [32], hq [32];
        for (int j = 0; j < n + 2; j++) begin
            @(negedge clk);
            if (j >= 2) begin
                chk({tag, "_i"}, oi[k], m_scale(hi[j-2], mg[k]));
                chk({tag, "_q"}, oq[k], m_scale(hq[j-2], mg[k]));
            end
            if (j < n) begin
                hi[j] = int'($urandom_range(0, 1048575)) - 524288;
                hq[j] = int'($urandom_range(0, 1048575)) - 524288;
                fi[k] = 20'(hi[j]);
                fq[k] = 20'(hq[j]);
            end
        end
    endtask

    task automatic chk_reset(input int k, input string tag);
        chk({tag, "_out_i"}, oi[k], 0);
        chk({tag, "_out_q"}, oq[k], 0);
        chk({tag, "_gain"}, g[k], 16'h4000);
        chk({tag, "_flags"}, {bsy[k], lck[k], fl[k]}, 0);
    endtask

    initial begin
        reset_b = 1'b0;
        for (int k = 0; k < 3; k++) begin
            start_a[k] = 1'b0;
            ri[k] = '0; rq[k] = '0; fi[k] = '0; fq[k] = '0;
            mg[k] = 16'h4000;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) chk_reset(k, $sformatf("reset%0d", k));
        reset_b = 1'b1;

        // Unity gain pass-through, checking the exact 2-cycle latency.
        @(negedge clk);
        fi[0] = 20'sd100000;
        fq[0] = -20'sd50000;
        @(negedge clk);
        chk("pass_lat1_i", oi[0], 0);
        @(negedge clk);
        chk("pass_lat2_i", oi[0], 100000);
        chk("pass_lat2_q", oq[0], -50000);
        chk("pass_gain", g[0], 16'h4000);

        // Immediate lock, with a stray start while busy that must be ignored.
        ri[0] = 20'sd100000; rq[0] = '0;
        fi[0] = 20'sd100000; fq[0] = '0;
        run_cal(0, "imm_lock", 1'b1);

        // Upward convergence to 2.0.
        ri[1] = 20'sd200000; rq[1] = '0;
        fi[1] = 20'sd100000; fq[1] = '0;
        run_cal(1, "conv_up", 1'b0);
        chk("conv_up_gain_abs", g[1], 16'h8000);
        dp_rand(1, 24, "dp_gain2");

        // Dead feedback: gain walks up STEP per iteration and the run fails.
        ri[0] = 20'sd100000; rq[0] = '0;
        fi[0] = '0;          fq[0] = '0;
        run_cal(0, "fail_run", 1'b0);
        chk("fail_gain_abs", g[0], 16'h4400);

        // Clamp at 0xFFFF, then check output saturation.
        ri[2] = 20'sd400000; rq[2] = '0;
        fi[2] = 20'sd100000; fq[2] = '0;
        run_cal(2, "clamp_hi", 1'b0);
        chk("clamp_hi_gain_abs", g[2], 16'hFFFF);
        fi[2] = -20'sd524288;
        fq[2] = 20'sd524287;
        repeat (2) @(negedge clk);
        chk("sat_neg", oi[2], -524288);
        chk("sat_pos", oq[2], 524287);
        dp_rand(2, 24, "dp_gainmax");

        // Randomized calibration scenario.
        ri[1] = 20'(50000 + int'($urandom_range(0, 350000)));
        rq[1] = 20'(int'($urandom_range(0, 100000)) - 50000);
        fi[1] = 20'(50000 + int'($urandom_range(0, 200000)));
        fq[1] = 20'(int'($urandom_range(0, 80000)) - 40000);
        run_cal(1, "rand_cal", 1'b0);

        // Reset in the middle of an accumulation window.
        ri[0] = 20'sd100000; rq[0] = '0;
        fi[0] = 20'sd100000; fq[0] = '0;
        @(negedge clk);
        start_a[0] = 1'b1;
        @(negedge clk);
        start_a[0] = 1'b0;
        repeat (100) @(negedge clk);
        chk("mid_busy_pre", bsy[0], 1);
        #2 reset_b = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) chk_reset(k, $sformatf("mid_rst%0d", k));
        repeat (2) @(negedge clk);
        reset_b = 1'b1;
        for (int k = 0; k < 3; k++) mg[k] = 16'h4000;
        repeat (5) @(negedge clk);
        chk("post_rst_idle", bsy[0], 0);
        run_cal(0, "post_rst", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
